// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the control unit and the multiply/divide unit.
// Carries div_zero only when MULTDIV_DIV0_FLAG_EN is defined.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
`ifdef MULTDIV_DIV0_FLAG_EN
    logic             div_zero;

    modport master (output start, op, operand_a, operand_b,
                    input  busy, done, hi_out, lo_out, div_zero);
    modport slave  (input  start, op, operand_a, operand_b,
                    output busy, done, hi_out, lo_out, div_zero);
`else
    modport master (output start, op, operand_a, operand_b,
                    input  busy, done, hi_out, lo_out);
    modport slave  (input  start, op, operand_a, operand_b,
                    output busy, done, hi_out, lo_out);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) writing HI/LO.
// Optional MULTDIV_DIV0_FLAG_EN: divide-by-zero short-circuits and raises div_zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              op_q, a_neg, b_neg;
    logic [2*WIDTH:0]  acc;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  rem, quo, dmag;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    booth_sum;
    logic [WIDTH:0]    shifted;
    logic [WIDTH-1:0]  diff;
    logic              sub_ok;
    logic [WIDTH-1:0]  q_fix, r_fix;
    logic              done_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              dz_start;

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

`ifdef MULTDIV_DIV0_FLAG_EN
    logic dz_q, dz_flag;
    assign dz_start     = bus.op && (bus.operand_b == '0);
    assign bus.div_zero = dz_flag;
`else
    assign dz_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = dz_start ? FINISH : CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign a_mag = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    assign b_mag = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

    // Booth add is done one bit wider so A - (-2^(W-1)) cannot overflow before the shift.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
            default: ;
        endcase
    end

    // Partial remainder is always < divisor, so the difference fits WIDTH bits mod 2^WIDTH.
    assign shifted = {rem, quo[WIDTH-1]};
    assign sub_ok  = shifted[WIDTH] || (shifted[WIDTH-1:0] >= dmag);
    assign diff    = shifted[WIDTH-1:0] - dmag;

    assign q_fix = (a_neg ^ b_neg) ? -quo : quo;
    assign r_fix = a_neg ? -rem : rem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            op_q   <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            rem    <= '0;
            quo    <= '0;
            dmag   <= '0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef MULTDIV_DIV0_FLAG_EN
            dz_q    <= 1'b0;
            dz_flag <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (bus.start) begin
                    cnt   <= '0;
                    op_q  <= bus.op;
                    a_neg <= bus.operand_a[WIDTH-1];
                    b_neg <= bus.operand_b[WIDTH-1];
                    mcand <= bus.operand_a;
                    acc   <= {{WIDTH{1'b0}}, bus.operand_b, 1'b0};
                    rem   <= '0;
                    quo   <= a_mag;
                    dmag  <= b_mag;
`ifdef MULTDIV_DIV0_FLAG_EN
                    dz_q    <= dz_start;
                    dz_flag <= 1'b0;
`endif
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_q) begin
                        rem <= sub_ok ? diff : shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], sub_ok};
                    end else begin
                        acc <= {booth_sum, acc[WIDTH:1]};
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
`ifdef MULTDIV_DIV0_FLAG_EN
                    dz_flag <= dz_q;
                    if (!dz_q) begin
`else
                    begin
`endif
                        if (op_q) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= acc[2*WIDTH:WIDTH+1];
                            lo_q <= acc[WIDTH:1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int passed = 0;

    function automatic void model(input bit o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (sb == 0) begin
            h = a;
            l = a[31] ? 32'h1 : 32'hFFFF_FFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    // Called at the negedge after the start edge; returns edges counted until done.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input bit o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 1'($urandom_range(0, 1));
        bus.operand_a = $urandom; bus.operand_b = $urandom;
        wait_done(lat, busy_ok);
        h = bus.hi_out;
        l = bus.lo_out;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        checks++; if (bus.hi_out !== 32'h0) $display("FAIL reset_hi: got %h want 0", bus.hi_out); else passed++;
        checks++; if (bus.lo_out !== 32'h0) $display("FAIL reset_lo: got %h want 0", bus.lo_out); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_mult_directed;
        logic [31:0] h, l; int lat; bit bok;
        run_op(1'b0, 32'h7, 32'hFFFF_FFFD, h, l, lat, bok);
        checks++; if (lat !== 33) $display("FAIL mul_latency: got %0d want 33", lat); else passed++;
        checks++; if (!bok) $display("FAIL mul_busy: busy dropped before done"); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL mul_busy_at_done: got %b want 0", bus.busy); else passed++;
        checks++; if (h !== 32'hFFFF_FFFF) $display("FAIL mul_7x-3_hi: got %h want ffffffff", h); else passed++;
        checks++; if (l !== 32'hFFFF_FFEB) $display("FAIL mul_7x-3_lo: got %h want ffffffeb", l); else passed++;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", bus.done); else passed++;
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, h, l, lat, bok);
        checks++; if ({h, l} !== 64'h4000_0000_0000_0000) $display("FAIL mul_minxmin: got %h%h want 4000000000000000", h, l); else passed++;
        run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, h, l, lat, bok);
        checks++; if ({h, l} !== 64'h3FFF_FFFF_0000_0001) $display("FAIL mul_maxxmax: got %h%h want 3fffffff00000001", h, l); else passed++;
    endtask

    task automatic test_div_directed;
        logic [31:0] h, l; int lat; bit bok;
        run_op(1'b1, 32'hFFFF_FFF9, 32'h2, h, l, lat, bok);
        checks++; if (lat !== 33) $display("FAIL div_latency: got %0d want 33", lat); else passed++;
        checks++; if (l !== 32'hFFFF_FFFD) $display("FAIL div_-7/2_lo: got %h want fffffffd", l); else passed++;
        checks++; if (h !== 32'hFFFF_FFFF) $display("FAIL div_-7/2_hi: got %h want ffffffff", h); else passed++;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, h, l, lat, bok);
        checks++; if ({h, l} !== 64'h0000_0000_8000_0000) $display("FAIL div_overflow: got %h%h want 0000000080000000", h, l); else passed++;
    endtask

    task automatic test_random;
        logic [31:0] a, b, h, l, eh, el; int lat; bit bok, o;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = $urandom_range(1, 20);
            if (i % 4 == 2) b = -$urandom_range(1, 20);
            if (b == 0) b = 32'h3;
            model(o, a, b, eh, el);
            run_op(o, a, b, h, l, lat, bok);
            checks++;
            if ({h, l} !== {eh, el} || lat != 33)
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h_%h lat %0d want %h_%h lat 33",
                         i, o, a, b, h, l, lat, eh, el);
            else passed++;
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] a, b, eh, el; int lat; bit bok, seen;
        a = $urandom; b = $urandom;
        model(1'b0, a, b, eh, el);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.operand_a = 32'h1234_5678; bus.operand_b = 32'h3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bok);
        checks++; if (lat + 10 != 33) $display("FAIL ignore_latency: got %0d want 33", lat + 10); else passed++;
        checks++;
        if ({bus.hi_out, bus.lo_out} !== {eh, el})
            $display("FAIL ignore_result: got %h_%h want %h_%h", bus.hi_out, bus.lo_out, eh, el);
        else passed++;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.done || bus.busy) seen = 1'b1; end
        checks++; if (seen) $display("FAIL ignore_no_restart: got activity want idle"); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] h, l, a, b, eh, el; int lat; bit bok;
        run_op(1'b0, 32'h11, 32'h22, h, l, lat, bok);
        a = $urandom; b = $urandom_range(1, 1000);
        model(1'b1, a, b, eh, el);
        bus.start = 1'b1; bus.op = 1'b1; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bok);
        checks++; if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat); else passed++;
        checks++;
        if ({bus.hi_out, bus.lo_out} !== {eh, el})
            $display("FAIL b2b_result: got %h_%h want %h_%h", bus.hi_out, bus.lo_out, eh, el);
        else passed++;
    endtask

    task automatic test_div_zero;
        logic [31:0] h, l, ph, pl; int lat; bit bok;
        run_op(1'b0, 32'h9, 32'h9, ph, pl, lat, bok);
        run_op(1'b1, 32'h5, 32'h0, h, l, lat, bok);
`ifdef MULTDIV_DIV0_FLAG_EN
        checks++; if (lat !== 1) $display("FAIL div0_latency: got %0d want 1", lat); else passed++;
        checks++; if (bus.div_zero !== 1'b1) $display("FAIL div0_flag: got %b want 1", bus.div_zero); else passed++;
        checks++; if ({h, l} !== {ph, pl}) $display("FAIL div0_hold: got %h_%h want %h_%h", h, l, ph, pl); else passed++;
        run_op(1'b0, 32'h2, 32'h3, h, l, lat, bok);
        checks++; if (bus.div_zero !== 1'b0) $display("FAIL div0_clear: got %b want 0", bus.div_zero); else passed++;
`else
        checks++; if (lat !== 33) $display("FAIL div0_latency: got %0d want 33", lat); else passed++;
        checks++; if ({h, l} !== 64'h0000_0005_FFFF_FFFF) $display("FAIL div0_result: got %h_%h want 00000005_ffffffff", h, l); else passed++;
        checks++; if ({ph, pl} !== 64'h51) $display("FAIL div0_pre_mul: got %h_%h want 00000000_00000051", ph, pl); else passed++;
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l, a, b, eh, el; int lat; bit bok, seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'hDEAD_BEEF; bus.operand_b = 32'h1357_9BDF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.hi_out, bus.lo_out} !== 66'h0)
            $display("FAIL midreset_state: got busy %b done %b hi %h lo %h want all 0",
                     bus.busy, bus.done, bus.hi_out, bus.lo_out);
        else passed++;
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.done) seen = 1'b1; end
        checks++; if (seen) $display("FAIL midreset_no_done: got done pulse want none"); else passed++;
        a = $urandom; b = $urandom;
        model(1'b0, a, b, eh, el);
        run_op(1'b0, a, b, h, l, lat, bok);
        checks++;
        if ({h, l} !== {eh, el} || lat != 33)
            $display("FAIL midreset_fresh: got %h_%h lat %0d want %h_%h lat 33", h, l, lat, eh, el);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_mult_directed;
        test_div_directed;
        test_random;
        test_busy_ignore;
        test_back_to_back;
        test_div_zero;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
